// File: rtl/ddc_sweep_pkg.sv
// Shared types for the DDC frequency-sweep scheduler: FSM state encoding and
// the channel-index width helper used by the top and the pvalid pacer.
package ddc_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RECORD,
        NEXT,
        DONE
    } state_t;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddc_sweep_pacer.sv
// Paces the per-channel config strobes during LOAD: one fire every PV_GAP cycles
// for channels 0..N_CH-1, then a finished flag PV_GAP cycles after the last fire.
module ddc_sweep_pacer
    import ddc_sweep_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int PV_GAP = 16,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_run,
    output logic            o_fire,
    output logic [CH_W-1:0] o_ch,
    output logic            o_last_done
);
    localparam int TMR_W = ch_w(PV_GAP);
    localparam int CNT_W = CH_W + 1;

    logic [TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tmr_zero;
    logic             w_all_sent;

    assign w_tmr_zero = (r_tmr == '0);
    assign w_all_sent = (r_cnt == CNT_W'(N_CH));

    // Timer and channel count restart from zero on every entry into LOAD.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_tmr <= '0;
            r_cnt <= '0;
        end else if (r_tmr == TMR_W'(PV_GAP - 1)) begin
            r_tmr <= '0;
            if (!w_all_sent) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    assign o_fire      = i_run && w_tmr_zero && !w_all_sent;
    assign o_ch        = r_cnt[CH_W-1:0];
    assign o_last_done = i_run && w_tmr_zero && w_all_sent;

endmodule

// File: rtl/ddc_sweep_ctrl.sv
// Frequency-sweep scheduler: retunes every DDC channel per step over the
// ch/pinc/poff/pvalid path, skips settle frames and flags frames to record.
module ddc_sweep_ctrl
    import ddc_sweep_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PINC_WIDTH = 32,
    parameter int STEP_WIDTH = 16,
    parameter int FRM_WIDTH  = 16,
    parameter int PV_GAP     = 16,
    localparam int CH_W      = ch_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [PINC_WIDTH-1:0] cfg_pinc,
    input  logic [PINC_WIDTH-1:0] cfg_poff,
    input  logic [PINC_WIDTH-1:0] step_pinc,
    input  logic [STEP_WIDTH-1:0] n_steps,
    input  logic [FRM_WIDTH-1:0]  settle_frames,
    input  logic [FRM_WIDTH-1:0]  avg_frames,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  frame_start,
    output logic [CH_W-1:0]       ch,
    output logic [PINC_WIDTH-1:0] pinc,
    output logic [PINC_WIDTH-1:0] poff,
    output logic                  pvalid,
    output logic                  rec_en,
    output logic [STEP_WIDTH-1:0] step_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    state_t r_state;
    state_t w_state_next;

    logic [PINC_WIDTH-1:0] r_base     [N_CH];
    logic [PINC_WIDTH-1:0] r_poff_tab [N_CH];
    logic [PINC_WIDTH-1:0] r_cur_pinc [N_CH];

    logic [STEP_WIDTH-1:0] r_n_steps;
    logic [STEP_WIDTH-1:0] r_step_idx;
    logic [FRM_WIDTH-1:0]  r_settle;
    logic [FRM_WIDTH-1:0]  r_avg;
    logic [FRM_WIDTH:0]    r_frm_cnt;
    logic [FRM_WIDTH:0]    w_frm_now;

    logic                  r_pvalid;
    logic                  r_aborted;
    logic [CH_W-1:0]       r_ch;
    logic [PINC_WIDTH-1:0] r_pinc;
    logic [PINC_WIDTH-1:0] r_poff;

    logic                  w_busy;
    logic                  w_accept_start;
    logic                  w_fire;
    logic                  w_last_done;
    logic [CH_W-1:0]       w_fire_ch;

    ddc_sweep_pacer #(
        .N_CH  (N_CH),
        .PV_GAP(PV_GAP)
    ) u_pacer (
        .clk        (clk),
        .rst        (rst),
        .i_run      (r_state == LOAD),
        .o_fire     (w_fire),
        .o_ch       (w_fire_ch),
        .o_last_done(w_last_done)
    );

    assign w_busy         = (r_state != IDLE);
    assign w_accept_start = (r_state == IDLE) && start && !abort;
    // Frames counted so far in this state, including a pulse arriving this cycle.
    assign w_frm_now      = r_frm_cnt + {{FRM_WIDTH{1'b0}}, frame_start};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rec_en       = 1'b0;
        if (abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:   if (start) w_state_next = (n_steps == '0) ? DONE : LOAD;
                LOAD:   if (w_last_done) w_state_next = SETTLE;
                SETTLE: if (w_frm_now >= {1'b0, r_settle})
                            w_state_next = (r_avg == '0) ? NEXT : RECORD;
                RECORD: begin
                    rec_en = (w_frm_now != '0) && (w_frm_now <= {1'b0, r_avg});
                    if (frame_start && (r_frm_cnt == {1'b0, r_avg})) w_state_next = NEXT;
                end
                NEXT:   w_state_next = (r_step_idx == r_n_steps - 1'b1) ? DONE : LOAD;
                DONE:   w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Table has no reset; it is only meaningful after the host has written it.
    always_ff @(posedge clk) begin
        if (cfg_we && !w_busy) begin
            r_base[cfg_ch]     <= cfg_pinc;
            r_poff_tab[cfg_ch] <= cfg_poff;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (rst) begin
                r_cur_pinc[k] <= '0;
            end else if (w_accept_start) begin
                r_cur_pinc[k] <= r_base[k];
            end else if (r_state == NEXT && !abort) begin
                r_cur_pinc[k] <= r_cur_pinc[k] + step_pinc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_steps  <= '0;
            r_step_idx <= '0;
            r_settle   <= '0;
            r_avg      <= '0;
            r_frm_cnt  <= '0;
            r_pvalid   <= 1'b0;
            r_aborted  <= 1'b0;
            r_ch       <= '0;
            r_pinc     <= '0;
            r_poff     <= '0;
        end else begin
            r_aborted <= abort && w_busy;
            r_pvalid  <= w_fire && !abort;
            // Strobe payload stays on the bus until the next strobe overwrites it.
            if (w_fire && !abort) begin
                r_ch   <= w_fire_ch;
                r_pinc <= r_cur_pinc[w_fire_ch];
                r_poff <= r_poff_tab[w_fire_ch];
            end
            if (w_state_next != r_state) begin
                r_frm_cnt <= '0;
            end else if (frame_start && (r_state == SETTLE || r_state == RECORD)) begin
                r_frm_cnt <= w_frm_now;
            end
            if (w_accept_start) begin
                r_n_steps  <= n_steps;
                r_settle   <= settle_frames;
                r_avg      <= avg_frames;
                r_step_idx <= '0;
            end else if (r_state == NEXT && !abort) begin
                r_step_idx <= r_step_idx + 1'b1;
            end
        end
    end

    assign ch       = r_ch;
    assign pinc     = r_pinc;
    assign poff     = r_poff;
    assign pvalid   = r_pvalid && !abort;
    assign step_idx = r_step_idx;
    assign busy     = w_busy;
    assign done     = (r_state == DONE);
    assign aborted  = r_aborted;

endmodule

// File: tb/tb_ddc_sweep_ctrl.sv
// Randomized bench for ddc_sweep_ctrl: expected waveforms are derived from an
// event timeline (pulse times, frame counts) computed from the sweep rules.
module tb_ddc_sweep_ctrl;
    localparam int N    = 4;
    localparam int G    = 16;
    localparam int MAXT = 2048;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, abort, frame_start;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_pinc, cfg_poff, step_pinc;
    logic [15:0] n_steps, settle_frames, avg_frames;
    logic [1:0]  ch;
    logic [31:0] pinc, poff;
    logic        pvalid, rec_en, busy, done, aborted;
    logic [15:0] step_idx;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] m_base [N];
    logic [31:0] m_poff [N];
    bit          fs     [MAXT];
    bit          e_pv   [MAXT];
    bit          e_rec  [MAXT];
    bit          e_busy [MAXT];
    bit          e_done [MAXT];
    bit          e_abt  [MAXT];
    bit          e_sc   [MAXT];
    int          e_step [MAXT];
    logic [1:0]  e_ch   [MAXT];
    logic [31:0] e_pinc [MAXT];
    logic [31:0] e_poff [MAXT];
    logic [1:0]  h_ch;
    logic [31:0] h_pinc, h_poff;

    always #5 clk = ~clk;

    ddc_sweep_ctrl dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pinc(cfg_pinc),
        .cfg_poff(cfg_poff), .step_pinc(step_pinc), .n_steps(n_steps),
        .settle_frames(settle_frames), .avg_frames(avg_frames), .start(start),
        .abort(abort), .frame_start(frame_start), .ch(ch), .pinc(pinc), .poff(poff),
        .pvalid(pvalid), .rec_en(rec_en), .step_idx(step_idx), .busy(busy),
        .done(done), .aborted(aborted)
    );

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we = 0; start = 0; abort = 0; frame_start = 0; rst = 0;
    endtask

    task automatic program_table(input logic [31:0] b0, b1, b2, b3);
        logic [31:0] b [N];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 0; k < N; k++) begin
            tick();
            cfg_we = 1; cfg_ch = 2'(k); cfg_pinc = b[k]; cfg_poff = $urandom;
            m_base[k] = b[k]; m_poff[k] = cfg_poff;
        end
        tick();
        cfg_we = 0;
    endtask

    // Cycle of the k-th frame_start pulse at or after cycle 'from'.
    function automatic int nth_fs(input int from, input int k);
        int cnt = 0;
        for (int t = from; t < MAXT; t++) begin
            if (fs[t]) begin
                cnt++;
                if (cnt == k) return t;
            end
        end
        return MAXT - 8;
    endfunction

    // Timeline relative to the start cycle (t=0): LOAD entry L, pulses at L+1+k*G,
    // SETTLE entry L+1+N*G, then frame-counted RECORD, NEXT, DONE.
    task automatic build_model(input int n, input int st, input int av, input logic [31:0] stp,
                               input int ta, input int tr, output int t_end);
        logic [31:0] cur [N];
        int L, E, R, X, D, f1, fe, p;
        logic [1:0]  c;
        logic [31:0] pi, po;
        for (int t = 0; t < MAXT; t++) begin
            e_pv[t] = 0; e_rec[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_abt[t] = 0;
            e_sc[t] = 0; e_step[t] = 0; e_ch[t] = 0; e_pinc[t] = 0; e_poff[t] = 0;
        end
        D = 0;
        X = 0;
        if (ta != 0) begin
            if (n == 0) begin
                D = 1;
            end else begin
                for (int k = 0; k < N; k++) cur[k] = m_base[k];
                L = 1;
                for (int s = 0; s < n; s++) begin
                    for (int k = 0; k < N; k++) begin
                        p = L + 1 + k * G;
                        e_pv[p] = 1; e_ch[p] = 2'(k); e_pinc[p] = cur[k]; e_poff[p] = m_poff[k];
                        e_sc[p] = 1; e_step[p] = s;
                    end
                    E = L + 1 + N * G;
                    R = (st == 0) ? E + 1 : nth_fs(E, st) + 1;
                    if (av == 0) begin
                        X = R;
                    end else begin
                        f1 = nth_fs(R, 1);
                        fe = nth_fs(R, av + 1);
                        for (int t = f1; t < fe; t++) begin
                            e_rec[t] = 1; e_sc[t] = 1; e_step[t] = s;
                        end
                        X = fe + 1;
                    end
                    for (int k = 0; k < N; k++) cur[k] = cur[k] + stp;
                    L = X + 1;
                end
                D = X + 1;
            end
            for (int t = 1; t <= D; t++) e_busy[t] = 1;
            e_done[D] = 1;
        end
        t_end = D + 4;
        if (ta > 0 && ta <= D) begin
            e_pv[ta] = 0; e_rec[ta] = 0; e_sc[ta] = 0;
            for (int t = ta + 1; t < MAXT; t++) begin
                e_pv[t] = 0; e_rec[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_sc[t] = 0;
            end
            e_abt[ta + 1] = 1;
            t_end = ta + 4;
        end
        if (tr >= 0 && tr < t_end) begin
            for (int t = tr + 1; t < MAXT; t++) begin
                e_pv[t] = 0; e_rec[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_sc[t] = 0; e_abt[t] = 0;
            end
            e_sc[tr + 1] = 1; e_step[tr + 1] = 0;
            t_end = tr + 4;
        end
        c = h_ch; pi = h_pinc; po = h_poff;
        for (int t = 0; t <= t_end; t++) begin
            if (tr >= 0 && t > tr) begin
                c = 0; pi = 0; po = 0;
            end else if (e_pv[t]) begin
                c = e_ch[t]; pi = e_pinc[t]; po = e_poff[t];
            end
            e_ch[t] = c; e_pinc[t] = pi; e_poff[t] = po;
        end
    endtask

    task automatic run_sweep(input string name, input int n, input int st, input int av,
                             input logic [31:0] stp, input int ta, input bit rst_in_rec, input int tw);
        int t_end, tr, tf, npv_obs, npv_exp;
        for (int t = 0; t < MAXT; t++) fs[t] = 0;
        tf = $urandom_range(2, 10);
        while (tf < MAXT) begin
            fs[tf] = 1;
            tf += $urandom_range(3, 20);
        end
        tr = -1;
        build_model(n, st, av, stp, ta, tr, t_end);
        if (rst_in_rec) begin
            for (int t = 0; t < t_end; t++) if (e_rec[t] && tr < 0) tr = t + 1;
            build_model(n, st, av, stp, ta, tr, t_end);
        end
        npv_exp = 0;
        npv_obs = 0;
        for (int t = 0; t <= t_end; t++) if (e_pv[t]) npv_exp++;
        $display("sweep %s: n=%0d settle=%0d avg=%0d step=%08h abort_t=%0d rst_t=%0d", name, n, st, av, stp, ta, tr);
        for (int t = 0; t <= t_end; t++) begin
            tick();
            rst = (t == tr); start = (t == 0); abort = (t == ta); frame_start = fs[t];
            step_pinc = stp;
            cfg_we = (t == tw); cfg_ch = 2'($urandom); cfg_pinc = $urandom; cfg_poff = $urandom;
            if (t == 0) begin
                n_steps = 16'(n); settle_frames = 16'(st); avg_frames = 16'(av);
            end else begin
                n_steps = 16'($urandom); settle_frames = 16'($urandom); avg_frames = 16'($urandom);
            end
            @(negedge clk);
            check_val($sformatf("%s ctl(busy,done,pv,rec,abt) t=%0d", name, t),
                      {busy, done, pvalid, rec_en, aborted},
                      {e_busy[t], e_done[t], e_pv[t], e_rec[t], e_abt[t]});
            check_val($sformatf("%s ch/pinc/poff t=%0d", name, t), {ch, pinc, poff},
                      {e_ch[t], e_pinc[t], e_poff[t]});
            if (e_sc[t]) check_val($sformatf("%s step_idx t=%0d", name, t), step_idx, 16'(e_step[t]));
            if (pvalid) begin
                npv_obs++;
                $display("  pvalid t=%0d ch=%0d pinc=%08h poff=%08h step=%0d", t, ch, pinc, poff, step_idx);
            end
        end
        tick();
        idle_inputs();
        check_val({name, " pvalid count"}, 96'(npv_obs), 96'(npv_exp));
        h_ch = e_ch[t_end]; h_pinc = e_pinc[t_end]; h_poff = e_poff[t_end];
    endtask

    initial begin
        idle_inputs();
        cfg_ch = 0; cfg_pinc = 0; cfg_poff = 0; step_pinc = 0;
        n_steps = 0; settle_frames = 0; avg_frames = 0;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        check_val("reset ctl", {busy, done, pvalid, rec_en, aborted}, 5'b0);
        check_val("reset ch/pinc/poff", {ch, pinc, poff}, 66'b0);
        check_val("reset step_idx", step_idx, 16'h0);
        h_ch = 0; h_pinc = 0; h_poff = 0;

        program_table(32'h1000, 32'h2000, 32'h3000, 32'h4000);
        run_sweep("basic", 3, 1, 2, 32'h10, -1, 0, -1);
        program_table(32'hFFFF_FFF0, $urandom, $urandom, $urandom);
        run_sweep("wrap", 2, $urandom_range(0, 2), $urandom_range(1, 2), 32'h20, -1, 0, -1);
        program_table(32'd5, $urandom, $urandom, $urandom);
        run_sweep("negstep", 3, 1, 1, 32'hFFFF_FFFF, -1, 0, -1);
        run_sweep("nsteps0", 0, 1, 1, 32'h10, -1, 0, -1);
        run_sweep("noframes", 3, 0, 0, $urandom, -1, 0, -1);
        run_sweep("abort_load", 3, 1, 1, 32'h10, 2 + G + 3, 0, -1);
        run_sweep("start_abort", 3, 1, 1, 32'h10, 0, 0, -1);
        run_sweep("we_busy", 2, 1, 1, 32'h40, -1, 0, 5);
        run_sweep("after_we", 2, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, -1, 0, -1);
        run_sweep("rst_record", 2, 1, 2, 32'h10, -1, 1, -1);
        for (int i = 0; i < 4; i++) begin
            program_table($urandom, $urandom, $urandom, $urandom);
            run_sweep($sformatf("rand%0d", i), $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom, -1, 0, -1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
